// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: sequences one instruction at a time through fetch, execute,
// optional data access and commit. It drives the enable pins of the PC,
// instruction and writeback registers, bounds every memory wait with a
// timeout, and counts retired instructions.
module core_seq_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_run,
   input  logic        i_imem_ack,
   input  logic        i_dmem_ack,
   input  logic        i_is_mem,
   input  logic        i_is_store,
   output logic        o_imem_req,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic        o_ir_en,
   output logic        o_pc_en,
   output logic        o_commit,
   output logic        o_busy,
   output logic        o_err,
   output logic [31:0] o_retired
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_COMMIT = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   // Last wait cycle in which an ack is still accepted.
   localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state_r;
   state_t           next_s;
   logic [CNT_W-1:0] cnt_r;
   logic             store_r;
   logic [31:0]      retired_r;
   logic             waiting_s;

   // State register with synchronous reset back to IDLE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic; an ack in the final allowed wait cycle beats the timeout.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_run) next_s = ST_FETCH;
            else       next_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (i_imem_ack)                next_s = ST_EXEC;
            else if (cnt_r == CNT_LAST_C)  next_s = ST_ERR;
            else                           next_s = ST_FETCH;
         end
         ST_EXEC: begin
            if (i_is_mem) next_s = ST_MEM;
            else          next_s = ST_COMMIT;
         end
         ST_MEM: begin
            if (i_dmem_ack)                next_s = ST_COMMIT;
            else if (cnt_r == CNT_LAST_C)  next_s = ST_ERR;
            else                           next_s = ST_MEM;
         end
         ST_COMMIT: begin
            if (i_run) next_s = ST_FETCH;
            else       next_s = ST_IDLE;
         end
         ST_ERR:  next_s = ST_ERR;
         default: next_s = ST_IDLE;
      endcase
   end

   // Output decode; the IR enable follows the fetch ack in the same cycle.
   always_comb begin
      o_imem_req = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_ir_en    = 1'b0;
      o_pc_en    = 1'b0;
      o_commit   = 1'b0;
      o_busy     = 1'b0;
      o_err      = 1'b0;
      waiting_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            o_busy = 1'b0;
         end
         ST_FETCH: begin
            o_imem_req = 1'b1;
            o_ir_en    = i_imem_ack;
            o_busy     = 1'b1;
            waiting_s  = 1'b1;
         end
         ST_EXEC: begin
            o_busy = 1'b1;
         end
         ST_MEM: begin
            o_dmem_req = 1'b1;
            o_dmem_we  = store_r;
            o_busy     = 1'b1;
            waiting_s  = 1'b1;
         end
         ST_COMMIT: begin
            o_pc_en  = 1'b1;
            o_commit = 1'b1;
            o_busy   = 1'b1;
         end
         ST_ERR: begin
            o_err = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

   // Wait counter: counts unacknowledged cycles while a request stays in its
   // wait state, and restarts from zero on any state change.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (waiting_s && (next_s == state_r)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= {CNT_W{1'b0}};
      end
   end

   // Store flag captured while the decoded instruction is in EXEC.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         store_r <= 1'b0;
      end else if (state_r == ST_EXEC) begin
         store_r <= i_is_store;
      end else begin
         store_r <= store_r;
      end
   end

   // Retired-instruction counter; wraps silently at 2^32.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         retired_r <= 32'd0;
      end else if (state_r == ST_COMMIT) begin
         retired_r <= retired_r + 32'd1;
      end else begin
         retired_r <= retired_r;
      end
   end

   assign o_retired = retired_r;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: a behavioural instruction-level
// model is compared against the DUT on every cycle, plus directed scenarios
// with hand-computed expectations, then a randomized run.
module tb_core_seq_ctrl;

   localparam int TO = 4;

   localparam int P_IDLE   = 0;
   localparam int P_FETCH  = 1;
   localparam int P_EXEC   = 2;
   localparam int P_MEM    = 3;
   localparam int P_COMMIT = 4;
   localparam int P_ERR    = 5;

   logic        clk = 1'b0;
   logic        reset, run, imem_ack, dmem_ack, is_mem, is_store;
   logic        imem_req, dmem_req, dmem_we, ir_en, pc_en, commit, busy, err;
   logic [31:0] retired;

   int          cmp_tests = 0;
   int          cmp_fail  = 0;
   int          lit_tests = 0;
   int          lit_fail  = 0;

   int          m_ph    = P_IDLE;
   int          m_wait  = 0;
   logic        m_store = 1'b0;
   logic [31:0] m_ret   = 32'd0;
   bit          m_valid = 1'b0;
   bit          preload_ret = 1'b0;

   always #5 clk = ~clk;

   core_seq_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_run      (run),
      .i_imem_ack (imem_ack),
      .i_dmem_ack (dmem_ack),
      .i_is_mem   (is_mem),
      .i_is_store (is_store),
      .o_imem_req (imem_req),
      .o_dmem_req (dmem_req),
      .o_dmem_we  (dmem_we),
      .o_ir_en    (ir_en),
      .o_pc_en    (pc_en),
      .o_commit   (commit),
      .o_busy     (busy),
      .o_err      (err),
      .o_retired  (retired)
   );

   // Model compare and advance. Inputs only change just after the rising
   // edge, so values seen here are the ones the next edge will sample.
   always @(negedge clk) begin : model_blk
      logic [7:0] exp_v;
      logic [7:0] got_v;
      if (preload_ret) m_ret = 32'hFFFF_FFFF;
      if (m_valid) begin
         exp_v = {m_ph == P_FETCH, (m_ph == P_FETCH) && imem_ack,
                  m_ph == P_MEM,   (m_ph == P_MEM) && m_store,
                  m_ph == P_COMMIT, m_ph == P_COMMIT,
                  (m_ph >= P_FETCH) && (m_ph <= P_COMMIT),
                  m_ph == P_ERR};
         got_v = {imem_req, ir_en, dmem_req, dmem_we, pc_en, commit, busy, err};
         cmp_tests++;
         if ((got_v !== exp_v) || (retired !== m_ret)) begin
            cmp_fail++;
            $display("FAIL model_cycle t=%0t outs(ireq,iren,dreq,we,pc,cm,busy,err)=%b expected %b retired=%h expected %h",
                     $time, got_v, exp_v, retired, m_ret);
         end
      end
      if (reset) begin
         m_ph = P_IDLE; m_wait = 0; m_store = 1'b0; m_ret = 32'd0; m_valid = 1'b1;
      end else begin
         case (m_ph)
            P_IDLE:   if (run) begin m_ph = P_FETCH; m_wait = 0; end
            P_FETCH: begin
               if (imem_ack) m_ph = P_EXEC;
               else if (m_wait + 1 >= TO) m_ph = P_ERR;
               else m_wait++;
            end
            P_EXEC: begin
               m_store = is_store;
               m_wait  = 0;
               m_ph    = is_mem ? P_MEM : P_COMMIT;
            end
            P_MEM: begin
               if (dmem_ack) m_ph = P_COMMIT;
               else if (m_wait + 1 >= TO) m_ph = P_ERR;
               else m_wait++;
            end
            P_COMMIT: begin
               m_ret  = m_ret + 32'd1;
               m_wait = 0;
               m_ph   = run ? P_FETCH : P_IDLE;
            end
            default: m_ph = P_ERR;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      lit_tests++;
      if (got !== exp) begin
         lit_fail++;
         $display("FAIL %s got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      lit_tests++;
      if (got !== exp) begin
         lit_fail++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   initial begin : stim
      int pc_cnt;
      int we_cnt;
      int cm_cnt;
      reset = 1'b1; run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
      is_mem = 1'b0; is_store = 1'b0;

      // Reset held for two edges with run high.
      tick(); tick();
      reset = 1'b0; imem_ack = 1'b1; is_mem = 1'b0;
      @(negedge clk);
      check32("reset_outs", {24'd0, imem_req, ir_en, dmem_req, dmem_we, pc_en, commit, busy, err}, 32'd0);
      check32("reset_retired", retired, 32'd0);
      tick();
      @(negedge clk);
      check1("fetch_after_reset", imem_req, 1'b1);
      check1("ir_en_zero_wait", ir_en, 1'b1);

      // Zero-wait ALU stream: one PC pulse every third cycle.
      pc_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         pc_cnt += int'(pc_en);
         tick();
         @(negedge clk);
      end
      check32("alu_pc_pulses", 32'(pc_cnt), 32'd4);
      check32("alu_retired", retired, 32'd4);
      check32("model_pin_alu", m_ret, 32'd4);

      // Store with two wait cycles on the data side.
      tick(); is_mem = 1'b1; is_store = 1'b1; imem_ack = 1'b0;
      we_cnt = 0; cm_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         dmem_ack = (i == 2);
         @(negedge clk);
         we_cnt += int'(dmem_req && dmem_we);
         cm_cnt += int'(commit);
      end
      check32("store_we_cycles", 32'(we_cnt), 32'd3);
      check32("store_commit_pulses", 32'(cm_cnt), 32'd1);

      // Load with run dropped during MEM, then a stray ack in IDLE.
      tick(); imem_ack = 1'b1; is_store = 1'b0;
      tick(); imem_ack = 1'b0;
      tick(); run = 1'b0; dmem_ack = 1'b1;
      @(negedge clk);
      check1("load_req", dmem_req, 1'b1);
      check1("load_we", dmem_we, 1'b0);
      tick(); dmem_ack = 1'b0;
      @(negedge clk);
      check1("run_drop_commit", commit, 1'b1);
      tick(); dmem_ack = 1'b1;
      @(negedge clk);
      check1("run_drop_idle_busy", busy, 1'b0);
      tick(); dmem_ack = 1'b0;
      @(negedge clk);
      check1("stray_ack_busy", busy, 1'b0);
      check1("stray_ack_dreq", dmem_req, 1'b0);
      check32("retired_six", retired, 32'd6);

      // Counter wrap from a preloaded all-ones value.
      tick();
      force dut.retired_r = 32'hFFFF_FFFF;
      preload_ret = 1'b1;
      tick();
      release dut.retired_r;
      preload_ret = 1'b0;
      @(negedge clk);
      check32("preload_held", retired, 32'hFFFF_FFFF);
      tick(); run = 1'b1; imem_ack = 1'b1; is_mem = 1'b0;
      tick(); run = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check1("wrap_commit", commit, 1'b1);
      tick();
      @(negedge clk);
      check32("retired_wrap", retired, 32'd0);
      check32("model_pin_wrap", m_ret, 32'd0);

      // Fetch ack in the last allowed cycle wins over the timeout.
      tick(); run = 1'b1; imem_ack = 1'b0;
      tick(); tick(); tick();
      tick(); imem_ack = 1'b1;
      @(negedge clk);
      check1("boundary_last_req", imem_req, 1'b1);
      tick(); imem_ack = 1'b0; is_mem = 1'b0;
      @(negedge clk);
      check1("boundary_exec_err", err, 1'b0);
      check1("boundary_exec_busy", busy, 1'b1);
      check1("boundary_exec_req", imem_req, 1'b0);

      // No ack at all: error on the fifth fetch-side cycle, sticky.
      tick(); tick();
      @(negedge clk);
      check1("timeout_req_first", imem_req, 1'b1);
      tick(); tick(); tick();
      @(negedge clk);
      check1("timeout_4th_no_err", err, 1'b0);
      tick();
      @(negedge clk);
      check1("timeout_err", err, 1'b1);
      check1("timeout_req_low", imem_req, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         imem_ack = 1'($urandom_range(0, 1));
         dmem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         check1("err_sticky", err, 1'b1);
      end

      // Reset out of ERR, then reset during a data wait.
      tick(); reset = 1'b1; dmem_ack = 1'b0; imem_ack = 1'b1; is_mem = 1'b1; is_store = 1'b1;
      tick(); reset = 1'b0;
      @(negedge clk);
      check1("err_cleared", err, 1'b0);
      tick(); tick();
      tick(); imem_ack = 1'b0; reset = 1'b1;
      @(negedge clk);
      check1("mem_wait_req", dmem_req, 1'b1);
      tick(); reset = 1'b0; dmem_ack = 1'b1;
      @(negedge clk);
      check1("mid_wait_reset_dreq", dmem_req, 1'b0);
      check1("mid_wait_reset_busy", busy, 1'b0);
      tick(); dmem_ack = 1'b0;
      @(negedge clk);
      check1("after_reset_fetch", imem_req, 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         tick();
         reset    = ($urandom_range(0, 59) == 0);
         run      = ($urandom_range(0, 9) != 0);
         imem_ack = 1'($urandom_range(0, 1));
         dmem_ack = 1'($urandom_range(0, 1));
         is_mem   = 1'($urandom_range(0, 1));
         is_store = 1'($urandom_range(0, 1));
      end
      tick();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", cmp_tests + lit_tests, cmp_fail + lit_fail);
      $finish;
   end

endmodule
